// File: rtl/config_chain_shifter.sv
// Serial configuration-chain engine: shifts host words LSB-first into one of N_CHAINS
// on-chip config shift registers, with programmable ConfigClk rate and ConfigOut readback.
module config_chain_shifter #(
    parameter int unsigned N_CHAINS    = 2,
    parameter int unsigned CHAIN_WIDTH = 5164,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned DIV_WIDTH   = 16,
    localparam int unsigned SEL_W      = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_W-1:0]      chain_sel,
    input  logic [DIV_WIDTH-1:0]  half_period,
    input  logic                  do_load,
    input  logic                  chip_rst_req,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  done,
    output logic [N_CHAINS-1:0]   ConfigClk,
    output logic [N_CHAINS-1:0]   ConfigIn,
    output logic [N_CHAINS-1:0]   ConfigLoad,
    output logic                  Reset_not,
    input  logic [N_CHAINS-1:0]   ConfigOut
);

    localparam int unsigned BIT_W = (CHAIN_WIDTH > 1) ? $clog2(CHAIN_WIDTH) : 1;
    localparam int unsigned WB_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOW,
        S_HIGH,
        S_LOADW,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DIV_WIDTH-1:0]  hp_q, hp_d;
    logic                  load_q, load_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [WB_W-1:0]       word_bit_q, word_bit_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] rx_buf_q, rx_buf_d;
    logic [WORD_WIDTH-1:0] rx_fill;
    logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [N_CHAINS-1:0]   cfg_clk_q, cfg_clk_d;
    logic [N_CHAINS-1:0]   cfg_in_q, cfg_in_d;
    logic [N_CHAINS-1:0]   cfg_load_q, cfg_load_d;
    logic                  rst_not_q;

    logic [N_CHAINS-1:0]   sel_mask;
    logic                  cfg_out_bit;
    logic                  hp_last;
    logic                  last_bit;
    logic                  word_end;

    // Out-of-range selects give an all-zero mask, so no pin can ever toggle for them.
    assign sel_mask    = N_CHAINS'(1) << sel_q;
    assign cfg_out_bit = |(ConfigOut & sel_mask);
    assign hp_last     = (div_q == (hp_q - DIV_WIDTH'(1)));
    assign last_bit    = (bit_q == BIT_W'(CHAIN_WIDTH - 1));
    assign word_end    = (word_bit_q == WB_W'(WORD_WIDTH - 1));

    // Next-state and next-output logic; pins are derived from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        hp_d       = hp_q;
        load_d     = load_q;
        div_d      = div_q;
        bit_d      = bit_q;
        word_bit_d = word_bit_q;
        shift_d    = shift_q;
        rx_buf_d   = rx_buf_q;
        rx_fill    = rx_buf_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d      = chain_sel;
                    hp_d       = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
                    load_d     = do_load;
                    div_d      = '0;
                    bit_d      = '0;
                    word_bit_d = '0;
                    rx_buf_d   = '0;
                    state_d    = (32'(chain_sel) < N_CHAINS) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (tx_valid) begin
                    shift_d    = tx_data;
                    word_bit_d = '0;
                    div_d      = '0;
                    state_d    = S_LOW;
                end
            end
            S_LOW: begin
                if (hp_last) begin
                    div_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    rx_fill[word_bit_q] = cfg_out_bit;
                end
                rx_buf_d = rx_fill;
                if (hp_last) begin
                    div_d      = '0;
                    bit_d      = bit_q + BIT_W'(1);
                    word_bit_d = word_bit_q + WB_W'(1);
                    shift_d    = shift_q >> 1;
                    if (last_bit || word_end) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_fill;
                        rx_buf_d   = '0;
                    end
                    if (last_bit) begin
                        state_d = load_q ? S_LOADW : S_DONE;
                    end else if (word_end) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            S_LOADW: begin
                if (hp_last) begin
                    div_d   = '0;
                    state_d = S_DONE;
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition and suppresses the partial-word strobe.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end

        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        tx_ready_d = (state_d == S_FETCH);
        cfg_clk_d  = (state_d == S_HIGH) ? sel_mask : '0;
        cfg_in_d   = (((state_d == S_LOW) || (state_d == S_HIGH)) && shift_d[0]) ? sel_mask : '0;
        cfg_load_d = (state_d == S_LOADW) ? sel_mask : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            hp_q       <= DIV_WIDTH'(1);
            load_q     <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            word_bit_q <= '0;
            shift_q    <= '0;
            rx_buf_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            cfg_clk_q  <= '0;
            cfg_in_q   <= '0;
            cfg_load_q <= '0;
            rst_not_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            hp_q       <= hp_d;
            load_q     <= load_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            word_bit_q <= word_bit_d;
            shift_q    <= shift_d;
            rx_buf_q   <= rx_buf_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_ready_q <= tx_ready_d;
            cfg_clk_q  <= cfg_clk_d;
            cfg_in_q   <= cfg_in_d;
            cfg_load_q <= cfg_load_d;
            rst_not_q  <= ~chip_rst_req;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ConfigClk  = cfg_clk_q;
    assign ConfigIn   = cfg_in_q;
    assign ConfigLoad = cfg_load_q;
    assign Reset_not  = rst_not_q;

endmodule

// File: tb/tb_config_chain_shifter.sv
// Scoreboard bench for config_chain_shifter: stimulus queues expected bits, rx words, loads
// and done pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_config_chain_shifter;

    localparam int unsigned NC = 3;
    localparam int unsigned CW = 40;
    localparam int unsigned WW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, do_load = 1'b0, chip_rst_req = 1'b0;
    logic [SW-1:0] chain_sel = '0;
    logic [DW-1:0] half_period = '0;
    logic [WW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, rx_valid, busy, done, Reset_not;
    logic [WW-1:0] rx_data;
    logic [NC-1:0] ConfigClk, ConfigIn, ConfigLoad, ConfigOut;

    always #5 clk = ~clk;

    config_chain_shifter #(.N_CHAINS(NC), .CHAIN_WIDTH(CW), .WORD_WIDTH(WW), .DIV_WIDTH(DW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .chain_sel(chain_sel), .half_period(half_period), .do_load(do_load),
        .chip_rst_req(chip_rst_req), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .done(done), .ConfigClk(ConfigClk), .ConfigIn(ConfigIn), .ConfigLoad(ConfigLoad),
        .Reset_not(Reset_not), .ConfigOut(ConfigOut)
    );

    // Chip-side model on chain 1: ConfigOut presents the bit shifted in 8 ConfigClk rises earlier.
    logic [7:0] dly;
    logic       mdl_out;
    logic       mdl_clr = 1'b1;
    always @(posedge ConfigClk[1] or posedge mdl_clr) begin
        if (mdl_clr) begin
            dly     <= '0;
            mdl_out <= 1'b0;
        end else begin
            mdl_out <= dly[7];
            dly     <= {dly[6:0], ConfigIn[1]};
        end
    end
    assign ConfigOut = {1'b0, mdl_out, 1'b0};

    logic        exp_bit[$];
    logic [31:0] exp_rx[$];
    int          exp_load[$];
    logic        exp_done[$];
    string       chk_nm[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];

    int checks = 0;
    int failures = 0;
    int rise_cnt = 0;
    int cur_sel = 1;
    int exp_hp = 1;

    function automatic void post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_nm.push_back(nm);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endfunction

    // Monitor: sole owner of the check/failure counters.
    initial begin : monitor
        logic [NC-1:0] prev_clk, prev_load;
        int            hi_len[NC];
        int            ld_len[NC];
        prev_clk  = '0;
        prev_load = '0;
        for (int c = 0; c < NC; c++) begin
            hi_len[c] = 0;
            ld_len[c] = 0;
        end
        forever begin
            @(negedge clk);
            while (chk_nm.size() > 0) begin
                string       nm;
                logic [31:0] a, e;
                nm = chk_nm.pop_front();
                a  = chk_act.pop_front();
                e  = chk_exp.pop_front();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, a, e);
                end
            end
            if (rst_n) begin
                for (int c = 0; c < NC; c++) begin
                    if (c != cur_sel) begin
                        checks++;
                        if (ConfigClk[c] || ConfigIn[c] || ConfigLoad[c]) begin
                            failures++;
                            $display("FAIL quiet_chain%0d: clk=%b in=%b load=%b expected all 0",
                                     c, ConfigClk[c], ConfigIn[c], ConfigLoad[c]);
                        end
                    end
                    if (ConfigClk[c] && !prev_clk[c]) begin
                        rise_cnt++;
                        hi_len[c] = 1;
                        checks++;
                        if (exp_bit.size() == 0) begin
                            failures++;
                            $display("FAIL bit_unexpected: chain%0d rise %0d with no bit expected", c, rise_cnt);
                        end else begin
                            logic e;
                            e = exp_bit.pop_front();
                            if (ConfigIn[c] !== e) begin
                                failures++;
                                $display("FAIL bit_value: chain%0d rise %0d got %b expected %b", c, rise_cnt, ConfigIn[c], e);
                            end
                        end
                    end else if (ConfigClk[c]) begin
                        hi_len[c]++;
                    end else if (prev_clk[c]) begin
                        checks++;
                        if (hi_len[c] != exp_hp) begin
                            failures++;
                            $display("FAIL clk_high_len: chain%0d got %0d expected %0d", c, hi_len[c], exp_hp);
                        end
                    end
                    if (ConfigLoad[c]) begin
                        ld_len[c]++;
                    end else if (prev_load[c]) begin
                        checks++;
                        if (exp_load.size() == 0) begin
                            failures++;
                            $display("FAIL load_unexpected: chain%0d got %0d cycles expected none", c, ld_len[c]);
                        end else begin
                            int e;
                            e = exp_load.pop_front();
                            if (ld_len[c] != e) begin
                                failures++;
                                $display("FAIL load_len: chain%0d got %0d expected %0d", c, ld_len[c], e);
                            end
                        end
                        ld_len[c] = 0;
                    end
                end
                prev_clk  = ConfigClk;
                prev_load = ConfigLoad;
                if (rx_valid) begin
                    checks++;
                    if (exp_rx.size() == 0) begin
                        failures++;
                        $display("FAIL rx_unexpected: got 0x%08h expected no word", rx_data);
                    end else begin
                        logic [31:0] e;
                        e = exp_rx.pop_front();
                        if (rx_data !== e) begin
                            failures++;
                            $display("FAIL rx_word: got 0x%08h expected 0x%08h", rx_data, e);
                        end
                    end
                end
                if (done) begin
                    checks++;
                    if (exp_done.size() == 0) begin
                        failures++;
                        $display("FAIL done_unexpected: got 1 expected 0");
                    end else begin
                        void'(exp_done.pop_front());
                        if (busy !== 1'b0) begin
                            failures++;
                            $display("FAIL done_busy: got %b expected 0", busy);
                        end
                    end
                end
            end
        end
    end

    task automatic feed(input logic [31:0] w, input int stall);
        int   n;
        logic clk_seen;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        post("fetch_timeout", 32'(n < 2000), 32'd1);
        clk_seen = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            clk_seen = clk_seen | (|ConfigClk);
        end
        if (stall > 0) begin
            post("stall_clk_low", 32'(clk_seen), 32'd0);
            post("stall_ready", 32'(tx_ready), 32'd1);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_bit.size() > 0 || exp_rx.size() > 0 || exp_done.size() > 0 ||
                exp_load.size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        post("run_timeout", 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic kick(input int sel, input int hp, input logic ld);
        chain_sel   = SW'(sel);
        half_period = DW'(hp);
        do_load     = ld;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic run(input int sel, input int hp, input logic ld, input logic [31:0] w0,
                       input logic [31:0] w1, input int stall, input logic [31:0] rx0,
                       input logic [31:0] rx1, input logic ghost);
        logic [39:0] s;
        mdl_clr = 1'b1;
        @(negedge clk);
        mdl_clr = 1'b0;
        cur_sel = sel;
        exp_hp  = (hp == 0) ? 1 : hp;
        s = {w1[7:0], w0};
        for (int k = 0; k < CW; k++) exp_bit.push_back(s[k]);
        exp_rx.push_back(rx0);
        exp_rx.push_back(rx1);
        if (ld) exp_load.push_back(exp_hp);
        exp_done.push_back(1'b1);
        kick(sel, hp, ld);
        post("busy_after_start", 32'(busy), 32'd1);
        feed(w0, 0);
        if (ghost) kick(0, 5, 1'b1);
        feed(w1, stall);
        wait_idle();
    endtask

    initial begin : stimulus
        int          base, n;
        logic [31:0] w;
        repeat (4) @(negedge clk);
        post("rst_pins", 32'({ConfigClk, ConfigIn, ConfigLoad}), 32'd0);
        post("rst_status", 32'({busy, done, rx_valid, tx_ready}), 32'd0);
        post("rst_rx_data", rx_data, 32'd0);
        post("rst_reset_not", 32'(Reset_not), 32'd1);
        rst_n   = 1'b1;
        mdl_clr = 1'b0;
        @(negedge clk);

        // Chain 1, hp=2, load; loopback gives the stream delayed by 8 bits.
        run(1, 2, 1'b1, 32'hA5A5A5A5, 32'h000000C3, 0, 32'hA5A5A500, 32'h000000A5, 1'b0);
        // Same with a 50-cycle stall before the second word.
        run(1, 2, 1'b1, 32'hA5A5A5A5, 32'h000000C3, 50, 32'hA5A5A500, 32'h000000A5, 1'b0);
        // hp=0 behaves as 1, no load, chain 0 reads back zeros.
        run(0, 0, 1'b0, 32'h12345678, 32'h0000005A, 0, 32'h00000000, 32'h00000000, 1'b0);

        // Abort after bit 17 completes.
        mdl_clr = 1'b1;
        @(negedge clk);
        mdl_clr = 1'b0;
        cur_sel = 1;
        exp_hp  = 1;
        w = 32'hDEADBEEF;
        for (int k = 0; k < 18; k++) exp_bit.push_back(w[k]);
        base = rise_cnt;
        kick(1, 1, 1'b1);
        feed(w, 0);
        n = 0;
        while (!((rise_cnt - base) >= 18 && ConfigClk[1] == 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        post("abort_wait_timeout", 32'(n < 500), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        post("abort_busy", 32'(busy), 32'd0);
        post("abort_pins", 32'({ConfigClk, ConfigIn, ConfigLoad}), 32'd0);
        post("abort_tx_ready", 32'(tx_ready), 32'd0);
        repeat (10) @(negedge clk);
        post("abort_bits_left", 32'(exp_bit.size()), 32'd0);
        post("abort_rises", 32'(rise_cnt - base), 32'd18);

        run(1, 1, 1'b1, 32'h0F0F1234, 32'h00000081, 0, 32'h0F123400, 32'h0000000F, 1'b0);
        // Start while busy (chain 0, hp=5) must be ignored.
        run(1, 1, 1'b0, 32'hFFFF0000, 32'h0000003C, 0, 32'hFF000000, 32'h000000FF, 1'b1);

        // Out-of-range chain: done next cycle, every chain quiet.
        cur_sel = 3;
        exp_done.push_back(1'b1);
        kick(3, 2, 1'b1);
        post("inv_done", 32'(done), 32'd1);
        post("inv_busy", 32'(busy), 32'd0);
        @(negedge clk);
        post("inv_done_once", 32'(done), 32'd0);
        post("inv_pins", 32'({ConfigClk, ConfigIn, ConfigLoad}), 32'd0);
        repeat (3) @(negedge clk);

        chip_rst_req = 1'b1;
        post("reset_not_before", 32'(Reset_not), 32'd1);
        @(negedge clk);
        post("reset_not_low", 32'(Reset_not), 32'd0);
        chip_rst_req = 1'b0;
        @(negedge clk);
        post("reset_not_high", 32'(Reset_not), 32'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
